// File: rtl/obstacle_generator_if.sv
// Obstacle column stream between the generator and the game datapath.
// The generator (master) drives columns; the datapath (slave) drives the scroll tick.
`timescale 1ns/1ps
interface obstacle_generator_if;
  logic       advance;
  logic [6:0] col;
  logic       col_is_pipe;
  logic [9:0] pipes_emitted;

  modport master (
    input  advance,
    output col,
    output col_is_pipe,
    output pipes_emitted
  );

  modport slave (
    output advance,
    input  col,
    input  col_is_pipe,
    input  pipes_emitted
  );
endinterface

// File: rtl/obstacle_generator.sv
// Endless seedable obstacle column generator: empty gaps separated by pipes whose
// gap-bottom height comes from a 16-bit Galois LFSR, range-folded and slew-limited.
`timescale 1ns/1ps
module obstacle_generator #(
  parameter int unsigned MIN_H    = 10,
  parameter int unsigned MAX_H    = 50,
  parameter int unsigned MAX_STEP = 12,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic [2:0]                  spacing,
  input  logic [15:0]                 seed_in,
  input  logic                        seed_load,
  obstacle_generator_if.master        obs
);

  localparam int unsigned SPAN = MAX_H - MIN_H;
  localparam int unsigned R    = SPAN + 1;
  localparam int unsigned MID  = (MIN_H + MAX_H) / 2;
  localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {
    S_INIT,
    S_GAP,
    S_PIPE
  } state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [6:0]  prev;
  logic [2:0]  gap_cnt;
  logic [2:0]  sp_eff;
  logic [6:0]  off;
  logic [7:0]  cand;
  logic [7:0]  prev8;
  logic [6:0]  height;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  always_comb begin
    sp_eff = (spacing == 3'd0) ? 3'd1 : spacing;
  end

  // Fold the 6-bit draw into [0, SPAN], then clamp toward the last pipe so the
  // bird can always reach the next gap; 8-bit compares keep prev-MAX_STEP safe.
  always_comb begin
    off = {1'b0, lfsr[5:0]};
    if (off > 7'(SPAN))
      off = off - 7'(R);
    cand  = 8'(MIN_H) + {1'b0, off};
    prev8 = {1'b0, prev};
    if (cand > prev8 + 8'(MAX_STEP))
      height = 7'(prev8 + 8'(MAX_STEP));
    else if (cand + 8'(MAX_STEP) < prev8)
      height = 7'(prev8 - 8'(MAX_STEP));
    else
      height = 7'(cand);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state             <= S_INIT;
      lfsr              <= SEED_SAFE;
      prev              <= 7'(MID);
      gap_cnt           <= sp_eff;
      obs.col           <= '0;
      obs.col_is_pipe   <= 1'b0;
      obs.pipes_emitted <= '0;
    end else if (start) begin
      state             <= S_INIT;
      prev              <= 7'(MID);
      gap_cnt           <= sp_eff;
      obs.col           <= '0;
      obs.col_is_pipe   <= 1'b0;
      obs.pipes_emitted <= '0;
      if (seed_load)
        lfsr <= (seed_in == 16'h0000) ? 16'h0001 : seed_in;
    end else begin
      case (state)
        S_INIT: state <= S_GAP;
        S_GAP: begin
          if (obs.advance) begin
            obs.col         <= '0;
            obs.col_is_pipe <= 1'b0;
            gap_cnt         <= gap_cnt - 3'd1;
            if (gap_cnt == 3'd1)
              state <= S_PIPE;
          end
        end
        S_PIPE: begin
          if (obs.advance) begin
            obs.col         <= height;
            obs.col_is_pipe <= 1'b1;
            prev            <= height;
            lfsr            <= lfsr_step(lfsr);
            if (obs.pipes_emitted != '1)
              obs.pipes_emitted <= obs.pipes_emitted + 10'd1;
            gap_cnt         <= sp_eff;
            state           <= S_GAP;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_generator.sv
// Scoreboarded bench for obstacle_generator: expected columns are queued when an
// advance is driven and compared when the DUT registers the column.
`timescale 1ns/1ps
module tb_obstacle_generator;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [2:0]  spacing;
  logic [15:0] seed_in;
  logic        seed_load;

  obstacle_generator_if obs_if();

  obstacle_generator #(
    .MIN_H    (10),
    .MAX_H    (50),
    .MAX_STEP (12),
    .SEED     (16'hACE1)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .spacing   (spacing),
    .seed_in   (seed_in),
    .seed_load (seed_load),
    .obs       (obs_if.master)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [6:0] col;
    logic       pipe;
    logic [9:0] pe;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  string phase = "init";
  int    last_pipe = 30;

  // reference model state
  logic [15:0] m_lfsr;
  int          m_prev;
  int          m_gap;
  bit          m_pipe;
  int          m_pe;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: got %0d expected %0d", phase, tag, got, exp);
    end
  endtask

  function automatic int model_height(input logic [15:0] l, input int prev);
    int off;
    int cand;
    off = int'(l[5:0]);
    if (off >= 41) off = off - 41;
    cand = 10 + off;
    if (cand > prev + 12) return prev + 12;
    if (cand < prev - 12) return prev - 12;
    return cand;
  endfunction

  function automatic int eff(input logic [2:0] sp);
    return (sp == 3'd0) ? 1 : int'(sp);
  endfunction

  task automatic model_init(input logic [2:0] sp);
    m_prev    = 30;
    m_gap     = eff(sp);
    m_pipe    = 1'b0;
    m_pe      = 0;
    last_pipe = 30;
  endtask

  task automatic model_adv(output exp_t e);
    int  h;
    bit  fb;
    if (!m_pipe) begin
      e = '{7'd0, 1'b0, 10'(m_pe)};
      m_gap--;
      if (m_gap == 0) m_pipe = 1'b1;
    end else begin
      h = model_height(m_lfsr, m_prev);
      m_prev = h;
      fb = m_lfsr[0];
      m_lfsr = {1'b0, m_lfsr[15:1]};
      if (fb) m_lfsr = m_lfsr ^ 16'hB400;
      if (m_pe < 1023) m_pe++;
      e = '{7'(h), 1'b1, 10'(m_pe)};
      m_gap  = eff(spacing);
      m_pipe = 1'b0;
    end
  endtask

  task automatic pulse_e(input exp_t e, input int idle);
    @(negedge clk);
    obs_if.advance = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    obs_if.advance = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  task automatic pulse_const(input int c, input int pe);
    exp_t e;
    e = '{7'(c), (c != 0), 10'(pe)};
    pulse_e(e, 0);
  endtask

  task automatic model_pulse(input int idle);
    exp_t e;
    model_adv(e);
    pulse_e(e, idle);
  endtask

  task automatic model_burst(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs_if.advance = 1'b1;
      model_adv(e);
      exp_q.push_back(e);
    end
    @(negedge clk);
    obs_if.advance = 1'b0;
  endtask

  task automatic restart(input logic load, input logic [15:0] seed, input logic [2:0] sp);
    @(negedge clk);
    start     = 1'b1;
    seed_load = load;
    seed_in   = seed;
    spacing   = sp;
    @(negedge clk);
    check("start_clears_pe", obs_if.pipes_emitted, 0);
    start     = 1'b0;
    seed_load = 1'b0;
    if (load) m_lfsr = (seed == 16'h0000) ? 16'h0001 : seed;
    model_init(sp);
  endtask

  // monitor: compare the column registered on each edge that sampled advance
  initial begin
    logic adv_s;
    exp_t e;
    int   diff;
    forever begin
      @(posedge clk);
      adv_s = obs_if.advance;
      #1;
      if (adv_s) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("col", obs_if.col, e.col);
          check("col_is_pipe", obs_if.col_is_pipe, e.pipe);
          check("pipes_emitted", obs_if.pipes_emitted, e.pe);
          if (obs_if.col_is_pipe === 1'b1) begin
            check("range", (obs_if.col >= 7'd10 && obs_if.col <= 7'd50), 1);
            diff = int'(obs_if.col) - last_pipe;
            check("slew", (diff <= 12 && diff >= -12), 1);
            last_pipe = int'(obs_if.col);
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int sp;
    resetn         = 1'b0;
    start          = 1'b0;
    obs_if.advance = 1'b0;
    spacing        = 3'd3;
    seed_in        = '0;
    seed_load      = 1'b0;
    m_lfsr         = 16'hACE1;
    repeat (3) @(negedge clk);

    phase = "reset";
    check("col", obs_if.col, 0);
    check("col_is_pipe", obs_if.col_is_pipe, 0);
    check("pipes_emitted", obs_if.pipes_emitted, 0);
    resetn = 1'b1;
    m_lfsr = 16'hACE1;
    model_init(3'd3);

    phase = "seq_sp3";
    pulse_const(0, 0);
    pulse_const(0, 0);
    pulse_const(0, 0);
    pulse_const(42, 1);
    pulse_const(0, 1);
    pulse_const(0, 1);
    pulse_const(0, 1);
    pulse_const(30, 2);
    check("pe_after8", obs_if.pipes_emitted, 2);

    phase = "seed_zero";
    restart(1'b1, 16'h0000, 3'd1);
    pulse_const(0, 0);
    pulse_const(18, 1);

    phase = "spacing1";
    restart(1'b1, 16'h1234, 3'd1);
    repeat (8) model_pulse(0);
    phase = "spacing0";
    restart(1'b1, 16'h1234, 3'd0);
    repeat (8) model_pulse(0);

    phase = "back_to_back";
    restart(1'b1, 16'hBEEF, 3'd2);
    model_burst(9);
    phase = "spaced_1000";
    restart(1'b1, 16'hBEEF, 3'd2);
    repeat (9) model_pulse(1000);

    phase = "start_high";
    @(negedge clk);
    start = 1'b1;
    repeat (4) pulse_const(0, 0);
    check("pe_start_high", obs_if.pipes_emitted, 0);

    phase = "saturate";
    restart(1'b1, 16'($urandom), 3'd1);
    model_burst(2200);
    check("pe_saturated", obs_if.pipes_emitted, 1023);

    phase = "random_seeds";
    for (int k = 0; k < 9; k++) begin
      sp = $urandom_range(0, 7);
      restart(1'b1, 16'($urandom), 3'(sp));
      model_burst(100 * (eff(3'(sp)) + 1));
    end

    phase = "reset_mid_gap";
    restart(1'b1, 16'h5555, 3'd3);
    repeat (2) model_pulse(0);
    @(negedge clk);
    resetn = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    check("col", obs_if.col, 0);
    check("col_is_pipe", obs_if.col_is_pipe, 0);
    check("pipes_emitted", obs_if.pipes_emitted, 0);
    resetn = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    m_lfsr = 16'hACE1;
    model_init(3'd3);
    pulse_const(0, 0);
    pulse_const(0, 0);
    pulse_const(0, 0);
    pulse_const(42, 1);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/obstacle_generator.md
# obstacle_generator

Produces the stream of 7-bit obstacle columns consumed by the game datapath: on each scroll tick it emits either an empty column (0) or a pipe whose gap bottom height is drawn from a 16-bit LFSR, range-folded and slew-limited so every pipe is reachable. It sits directly upstream of the datapath's obstacle shift register. It replaces the fixed four-pipe pattern with an endless, seedable, difficulty-adjustable sequence.

## Interface

- MIN_H, 10, lowest pipe gap bottom; must be ≥1 so 0 always means "no pipe".
- MAX_H, 50, highest pipe gap bottom; R = MAX_H−MIN_H+1 must satisfy 32 ≤ R ≤ 64.
- MAX_STEP, 12, largest allowed height change between consecutive pipes.
- SEED, 16'hACE1, LFSR value loaded on reset; nonzero.

- clk  in  1  system clock (50 MHz).
- resetn  in  1  reset: synchronous, active-low; clock clk.
- start  in  1  level; high while the game is in its ready state, holds the block in init.
- advance  in  1  single-cycle scroll tick, one column consumed per pulse.
- spacing  in  3  empty columns between pipes; 0 is treated as 1.
- seed_in  in  16  seed value for seed_load.
- seed_load  in  1  qualifies start: load seed_in into the LFSR.
- col  out  7  current column: 0 = empty, else pipe gap bottom height.
- col_is_pipe  out  1  high when col is a pipe.
- pipes_emitted  out  10  count of pipes emitted since reset/start, saturating at 1023.

## Operation

- LFSR: 16-bit Galois, right shift; if lfsr[0] then lfsr = (lfsr>>1) ^ 16'hB400, else lfsr>>1. Steps only when a pipe is emitted.
- Zero-lock guard: any load of 16'h0000 (SEED or seed_in) stores 16'h0001 instead.
- Candidate height: off = lfsr[5:0] (from pre-step value); if off > MAX_H−MIN_H then off = off − R; cand = MIN_H + off.
- Slew limit against prev (last emitted pipe height): if cand > prev+MAX_STEP then prev+MAX_STEP; if cand + MAX_STEP < prev then prev−MAX_STEP; else cand. Compare in 8 bits, no underflow. prev initial = (MIN_H+MAX_H)/2 (30 by default).
- sp_eff = (spacing==0) ? 1 : spacing; sampled only at gap-counter reload.
- States: S_INIT (reset or start high), S_GAP (gap_cnt>0), S_PIPE (gap_cnt==0, next advance emits pipe).
  - S_INIT → S_GAP on the first cycle with start low; gap_cnt was loaded with sp_eff in S_INIT.
  - S_GAP, advance: col=0, col_is_pipe=0, gap_cnt−1; reaching 0 → S_PIPE.
  - S_PIPE, advance: col=height, col_is_pipe=1, prev=height, LFSR steps, pipes_emitted+1 (saturating), gap_cnt=sp_eff → S_GAP.
- Reset: lfsr=SEED, prev=mid, gap_cnt=sp_eff, col=0, col_is_pipe=0, pipes_emitted=0, state S_INIT.
- start high: same as reset, except LFSR loads seed_in if seed_load, otherwise keeps its current value (each new game gets a different layout).
- resetn has priority over start; start has priority over advance (advance ignored in S_INIT).

## Timing

- col/col_is_pipe registered; they update on the edge that samples advance=1 and are valid from the next cycle.
- Outputs hold stable between advances; the datapath may sample any time before the next tick.
- One column per advance; back-to-back advance pulses (every cycle) are supported with no bubbles.
- A spacing change mid-gap takes effect at the next reload, never truncating the current gap.

## Test plan

- Reset, spacing=3, advance ×8 → col = 0,0,0,42,0,0,0,30; col_is_pipe high on pulses 4 and 8; pipes_emitted=2.
- start with seed_load=1, seed_in=0, spacing=1, advance ×2 → LFSR holds 0x0001; col = 0 then 18 (cand 11 clamped to 30−12).
- spacing=0 → same sequence as spacing=1 (alternating empty/pipe).
- Advance on consecutive cycles versus spaced 1000 cycles apart → identical col sequence. Advance while start high → col stays 0 and pipes_emitted stays 0.
- 2000 pipes with random seeds → every pipe in [10,50], |Δ| ≤ 12 between pipes, pipes_emitted saturates at 1023.
- resetn low mid-gap, with start high at the same time → reset values restored and LFSR=0xACE1; first pipe after release is again 42.
